decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
- D/E pipeline register between decode and execute in the 5-stage RV32I core.
- Captures decoded control and datapath fields each cycle.
- Inserts a bubble when the load-use stall is asserted, holds when execute is busy, and clears on a taken-branch/jump flush.
- Its D_E_* outputs feed the execute stage and the load-use hazard check.

Parameters:
- XLEN, 32, datapath width for pc, rs1/rs2 data and immediate
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  load-use stall from hazard detection; insert bubble
- hold  input  1  execute stage busy; freeze register contents
- flush  input  1  branch/jump taken in execute; kill instruction entering D/E
- d_valid  input  1  decode stage holds a valid instruction
- d_pc  input  XLEN  pc of decode instruction
- d_rs1_data  input  XLEN  register file read port 1
- d_rs2_data  input  XLEN  register file read port 2
- d_imm  input  XLEN  sign-extended immediate
- d_rs1_adr  input  5  source register 1 index
- d_rs2_adr  input  5  source register 2 index
- d_rd_adr  input  5  destination register index
- d_alu_op  input  ALUOP_W  ALU operation
- d_ld_en  input  1  load instruction
- d_st_en  input  1  store instruction
- d_rd_en  input  1  writes rd
- d_br_en  input  1  conditional branch
- d_jmp_en  input  1  JAL/JALR
- D_E_valid  output  1  registered valid
- D_E_pc, D_E_rs1_data, D_E_rs2_data, D_E_imm  output  XLEN each  registered datapath fields
- D_E_rs1_adr, D_E_rs2_adr, D_E_rd_adr  output  5 each  registered register indices
- D_E_alu_op  output  ALUOP_W  registered ALU op
- D_E_ld_en, D_E_st_en, D_E_rd_en, D_E_br_en, D_E_jmp_en  output  1 each  registered control

Behaviour:
- Reset: all outputs 0 immediately on rst rising, independent of clk; held 0 while rst high.
- First edge after rst low performs normal update.
- Latency: one cycle; inputs sampled at edge N appear on outputs after edge N.
- Per-edge action, priority order (exactly one applies):
  1. flush=1 → bubble
  2. hold=1 → all outputs keep current values
  3. stall=1 → bubble
  4. otherwise → load all d_* fields
- Loaded D_E_valid = d_valid. If d_valid=0, all control enables and D_E_rd_adr load as 0; datapath fields load as presented.
- Bubble: D_E_valid, ld_en, st_en, rd_en, br_en, jmp_en, alu_op, rd_adr, rs1_adr, rs2_adr = 0; pc, data and imm fields = 0.
- Bubble therefore presents D_E_rd_adr=0, so the hazard check never re-stalls on a bubble.
- stall and hold together: hold wins; no bubble, contents preserved; stall is re-evaluated next cycle.
- flush with hold: flush wins. Execute asserts flush only on its resolving cycle, when hold is 0.
- flush with stall: single bubble; no double counting.
- Consecutive stalls: one bubble per stalled cycle.
- Block is pure register plus priority mux; no combinational path from inputs to outputs.
- Upstream PC/F-D freeze on stall is not driven here.

Optional Feature:
- Macro: DE_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments by 1 on each edge where the stall action is taken (stall=1, hold=0, flush=0).
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst.
- Undefined: port and counter absent; functional behaviour otherwise identical.

Test Plan:
- Reset mid-stream: load d_pc=0x100 with d_rd_en=1, assert rst asynchronously between edges → all outputs 0 before next edge, stall_cnt=0.
- Normal load: d_valid=1, d_pc=0x40, d_rd_adr=5, d_ld_en=1, d_alu_op=0x3 → next cycle D_E_pc=0x40, D_E_rd_adr=5, D_E_ld_en=1, D_E_valid=1.
- Load-use bubble: stall=1 for one cycle with d_pc=0x44, d_rd_en=1 → D_E_valid=0, D_E_rd_en=0, D_E_rd_adr=0, D_E_pc=0; following cycle stall=0 loads 0x44; stall_cnt=1.
- Hold over stall: registered pc 0x48, hold=1 and stall=1 for 3 cycles → outputs stay pc=0x48, valid=1; stall_cnt unchanged.
- Flush priority: flush=1, stall=1, hold=1 with d_pc=0x80 → bubble (valid=0, all enables 0); stall_cnt unchanged.
- Counter saturation (DE_STALL_CNT_EN): force stall_cnt to 0xFFFF_FFFE, apply 3 stall cycles → reads 0xFFFF_FFFF, no wrap to 0.

Source files
------------

// File: rtl/decode_execute_reg.sv
// D/E pipeline register: captures decode fields, bubbles on flush/stall, freezes on hold.
// Optional macro DE_STALL_CNT_EN adds a saturating count of load-use bubbles (stall_cnt).
module decode_execute_reg #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               hold,
    input  logic               flush,
    input  logic               d_valid,
    input  logic [XLEN-1:0]    d_pc,
    input  logic [XLEN-1:0]    d_rs1_data,
    input  logic [XLEN-1:0]    d_rs2_data,
    input  logic [XLEN-1:0]    d_imm,
    input  logic [4:0]         d_rs1_adr,
    input  logic [4:0]         d_rs2_adr,
    input  logic [4:0]         d_rd_adr,
    input  logic [ALUOP_W-1:0] d_alu_op,
    input  logic               d_ld_en,
    input  logic               d_st_en,
    input  logic               d_rd_en,
    input  logic               d_br_en,
    input  logic               d_jmp_en,
    output logic               D_E_valid,
    output logic [XLEN-1:0]    D_E_pc,
    output logic [XLEN-1:0]    D_E_rs1_data,
    output logic [XLEN-1:0]    D_E_rs2_data,
    output logic [XLEN-1:0]    D_E_imm,
    output logic [4:0]         D_E_rs1_adr,
    output logic [4:0]         D_E_rs2_adr,
    output logic [4:0]         D_E_rd_adr,
    output logic [ALUOP_W-1:0] D_E_alu_op,
    output logic               D_E_ld_en,
    output logic               D_E_st_en,
    output logic               D_E_rd_en,
    output logic               D_E_br_en,
    output logic               D_E_jmp_en
`ifdef DE_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] ACT_LOAD   = 2'd0;
    localparam logic [1:0] ACT_HOLD   = 2'd1;
    localparam logic [1:0] ACT_BUBBLE = 2'd2;

    logic [1:0]         action_c;
    logic               stall_take_c;

    logic               nxt_valid;
    logic [XLEN-1:0]    nxt_pc;
    logic [XLEN-1:0]    nxt_rs1_data;
    logic [XLEN-1:0]    nxt_rs2_data;
    logic [XLEN-1:0]    nxt_imm;
    logic [4:0]         nxt_rs1_adr;
    logic [4:0]         nxt_rs2_adr;
    logic [4:0]         nxt_rd_adr;
    logic [ALUOP_W-1:0] nxt_alu_op;
    logic               nxt_ld_en;
    logic               nxt_st_en;
    logic               nxt_rd_en;
    logic               nxt_br_en;
    logic               nxt_jmp_en;

    // Edge action: flush beats hold beats stall beats load.
    always_comb begin
        action_c     = ACT_LOAD;
        stall_take_c = 1'b0;
        if (flush) begin
            action_c = ACT_BUBBLE;
        end else if (hold) begin
            action_c = ACT_HOLD;
        end else if (stall) begin
            action_c     = ACT_BUBBLE;
            stall_take_c = 1'b1;
        end
    end

    // Next contents; default keeps current values (hold).
    always_comb begin
        nxt_valid    = D_E_valid;
        nxt_pc       = D_E_pc;
        nxt_rs1_data = D_E_rs1_data;
        nxt_rs2_data = D_E_rs2_data;
        nxt_imm      = D_E_imm;
        nxt_rs1_adr  = D_E_rs1_adr;
        nxt_rs2_adr  = D_E_rs2_adr;
        nxt_rd_adr   = D_E_rd_adr;
        nxt_alu_op   = D_E_alu_op;
        nxt_ld_en    = D_E_ld_en;
        nxt_st_en    = D_E_st_en;
        nxt_rd_en    = D_E_rd_en;
        nxt_br_en    = D_E_br_en;
        nxt_jmp_en   = D_E_jmp_en;
        case (action_c)
            ACT_LOAD: begin
                // An invalid slot never carries side effects or a destination to the hazard check.
                nxt_valid    = d_valid;
                nxt_pc       = d_pc;
                nxt_rs1_data = d_rs1_data;
                nxt_rs2_data = d_rs2_data;
                nxt_imm      = d_imm;
                nxt_rs1_adr  = d_rs1_adr;
                nxt_rs2_adr  = d_rs2_adr;
                nxt_rd_adr   = d_valid ? d_rd_adr : 5'd0;
                nxt_alu_op   = d_alu_op;
                nxt_ld_en    = d_valid & d_ld_en;
                nxt_st_en    = d_valid & d_st_en;
                nxt_rd_en    = d_valid & d_rd_en;
                nxt_br_en    = d_valid & d_br_en;
                nxt_jmp_en   = d_valid & d_jmp_en;
            end
            ACT_BUBBLE: begin
                nxt_valid    = 1'b0;
                nxt_pc       = '0;
                nxt_rs1_data = '0;
                nxt_rs2_data = '0;
                nxt_imm      = '0;
                nxt_rs1_adr  = 5'd0;
                nxt_rs2_adr  = 5'd0;
                nxt_rd_adr   = 5'd0;
                nxt_alu_op   = '0;
                nxt_ld_en    = 1'b0;
                nxt_st_en    = 1'b0;
                nxt_rd_en    = 1'b0;
                nxt_br_en    = 1'b0;
                nxt_jmp_en   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_E_valid    <= 1'b0;
            D_E_pc       <= '0;
            D_E_rs1_data <= '0;
            D_E_rs2_data <= '0;
            D_E_imm      <= '0;
            D_E_rs1_adr  <= 5'd0;
            D_E_rs2_adr  <= 5'd0;
            D_E_rd_adr   <= 5'd0;
            D_E_alu_op   <= '0;
            D_E_ld_en    <= 1'b0;
            D_E_st_en    <= 1'b0;
            D_E_rd_en    <= 1'b0;
            D_E_br_en    <= 1'b0;
            D_E_jmp_en   <= 1'b0;
        end else begin
            D_E_valid    <= nxt_valid;
            D_E_pc       <= nxt_pc;
            D_E_rs1_data <= nxt_rs1_data;
            D_E_rs2_data <= nxt_rs2_data;
            D_E_imm      <= nxt_imm;
            D_E_rs1_adr  <= nxt_rs1_adr;
            D_E_rs2_adr  <= nxt_rs2_adr;
            D_E_rd_adr   <= nxt_rd_adr;
            D_E_alu_op   <= nxt_alu_op;
            D_E_ld_en    <= nxt_ld_en;
            D_E_st_en    <= nxt_st_en;
            D_E_rd_en    <= nxt_rd_en;
            D_E_br_en    <= nxt_br_en;
            D_E_jmp_en   <= nxt_jmp_en;
        end
    end

`ifdef DE_STALL_CNT_EN
    logic [CNT_W-1:0] nxt_stall_cnt;

    // Saturating count of load-use bubbles actually inserted.
    always_comb begin
        nxt_stall_cnt = stall_cnt;
        if (stall_take_c && (stall_cnt != {CNT_W{1'b1}})) begin
            nxt_stall_cnt = stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= nxt_stall_cnt;
        end
    end
`else
    logic unused_stall_take;
    assign unused_stall_take = stall_take_c;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: driver pushes hand-labelled expectations, monitor compares.
// Define DE_STALL_CNT_EN to also check the stall counter.
module tb_decode_execute_reg;

    localparam int LOAD = 0;
    localparam int HOLD = 1;
    localparam int BUB  = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_adr;
        logic [4:0]  rs2_adr;
        logic [4:0]  rd_adr;
        logic [3:0]  alu_op;
        logic        ld_en;
        logic        st_en;
        logic        rd_en;
        logic        br_en;
        logic        jmp_en;
    } de_t;

    typedef struct {
        de_t         o;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, hold, flush;
    logic        d_valid;
    logic [31:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
    logic [4:0]  d_rs1_adr, d_rs2_adr, d_rd_adr;
    logic [3:0]  d_alu_op;
    logic        d_ld_en, d_st_en, d_rd_en, d_br_en, d_jmp_en;
    logic        D_E_valid;
    logic [31:0] D_E_pc, D_E_rs1_data, D_E_rs2_data, D_E_imm;
    logic [4:0]  D_E_rs1_adr, D_E_rs2_adr, D_E_rd_adr;
    logic [3:0]  D_E_alu_op;
    logic        D_E_ld_en, D_E_st_en, D_E_rd_en, D_E_br_en, D_E_jmp_en;
`ifdef DE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    de_t  cur;
    logic [31:0] ecnt;
    event chk_ev;

    always #5 clk = ~clk;

    decode_execute_reg #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .hold(hold), .flush(flush),
        .d_valid(d_valid), .d_pc(d_pc), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data),
        .d_imm(d_imm), .d_rs1_adr(d_rs1_adr), .d_rs2_adr(d_rs2_adr), .d_rd_adr(d_rd_adr),
        .d_alu_op(d_alu_op), .d_ld_en(d_ld_en), .d_st_en(d_st_en), .d_rd_en(d_rd_en),
        .d_br_en(d_br_en), .d_jmp_en(d_jmp_en),
        .D_E_valid(D_E_valid), .D_E_pc(D_E_pc), .D_E_rs1_data(D_E_rs1_data),
        .D_E_rs2_data(D_E_rs2_data), .D_E_imm(D_E_imm), .D_E_rs1_adr(D_E_rs1_adr),
        .D_E_rs2_adr(D_E_rs2_adr), .D_E_rd_adr(D_E_rd_adr), .D_E_alu_op(D_E_alu_op),
        .D_E_ld_en(D_E_ld_en), .D_E_st_en(D_E_st_en), .D_E_rd_en(D_E_rd_en),
        .D_E_br_en(D_E_br_en), .D_E_jmp_en(D_E_jmp_en)
`ifdef DE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Instruction builder; ctrl = {ld, st, rd, br, jmp}.
    function automatic de_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                               input logic [3:0] op, input logic [4:0] ctrl);
        de_t d;
        d.valid    = v;
        d.pc       = pc;
        d.rs1_data = 32'hA000_0000 | pc;
        d.rs2_data = 32'hB000_0000 | pc;
        d.imm      = 32'hFFFF_FFF0 ^ pc;
        d.rs1_adr  = 5'(rd + 5'd1);
        d.rs2_adr  = 5'(rd + 5'd2);
        d.rd_adr   = rd;
        d.alu_op   = op;
        {d.ld_en, d.st_en, d.rd_en, d.br_en, d.jmp_en} = ctrl;
        return d;
    endfunction

    function automatic de_t exp_load(input de_t d);
        de_t e = d;
        if (!d.valid) begin
            e.rd_adr = 5'd0;
            {e.ld_en, e.st_en, e.rd_en, e.br_en, e.jmp_en} = 5'b0;
        end
        return e;
    endfunction

    task automatic drive(input de_t d);
        d_valid = d.valid; d_pc = d.pc; d_rs1_data = d.rs1_data; d_rs2_data = d.rs2_data;
        d_imm = d.imm; d_rs1_adr = d.rs1_adr; d_rs2_adr = d.rs2_adr; d_rd_adr = d.rd_adr;
        d_alu_op = d.alu_op; d_ld_en = d.ld_en; d_st_en = d.st_en; d_rd_en = d.rd_en;
        d_br_en = d.br_en; d_jmp_en = d.jmp_en;
    endtask

    // One clock with hand-chosen expected action; expectation queued at the edge.
    task automatic step(input logic f, input logic h, input logic s, input de_t d, input int act);
        exp_t e;
        flush = f; hold = h; stall = s;
        drive(d);
        @(posedge clk);
        if (rst) begin
            cur = '0;
            ecnt = 32'd0;
        end else begin
            if (act == LOAD) cur = exp_load(d);
            else if (act == BUB) cur = '0;
            if (s && !h && !f && ecnt != 32'hFFFF_FFFF) ecnt = ecnt + 32'd1;
        end
        e.o = cur;
        e.cnt = ecnt;
        q.push_back(e);
        #1;
    endtask

    // Monitor: compares on each falling edge, or on demand for the async reset case.
    initial begin
        exp_t e;
        de_t  a;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {D_E_valid, D_E_pc, D_E_rs1_data, D_E_rs2_data, D_E_imm, D_E_rs1_adr,
                     D_E_rs2_adr, D_E_rd_adr, D_E_alu_op, D_E_ld_en, D_E_st_en, D_E_rd_en,
                     D_E_br_en, D_E_jmp_en};
                checks++;
                if (a !== e.o) begin
                    errors++;
                    $display("FAIL de_regs check=%0d t=%0t got=%h want=%h", checks, $time, a, e.o);
                end
`ifdef DE_STALL_CNT_EN
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%h want=%h", $time, stall_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        de_t nop;
        exp_t e;
        nop = '0;
        cur = '0;
        ecnt = 32'd0;
        rst = 1'b1;
        flush = 1'b0; hold = 1'b0; stall = 1'b0;
        drive(nop);
        step(0, 0, 0, mk(1, 32'h40, 5'd5, 4'h3, 5'b10100), LOAD);
        step(0, 0, 0, nop, LOAD);
        rst = 1'b0;
        // Normal load then load-use bubble, then the stalled instruction enters.
        step(0, 0, 0, mk(1, 32'h40, 5'd5, 4'h3, 5'b10100), LOAD);
        step(0, 0, 1, mk(1, 32'h44, 5'd6, 4'h1, 5'b00100), BUB);
        step(0, 0, 0, mk(1, 32'h44, 5'd6, 4'h1, 5'b00100), LOAD);
        step(0, 0, 0, mk(1, 32'h48, 5'd7, 4'h2, 5'b00100), LOAD);
        // Hold over stall preserves pc 0x48.
        for (int i = 0; i < 3; i++) step(0, 1, 1, mk(1, 32'h4C, 5'd8, 4'h4, 5'b01000), HOLD);
        // Flush beats hold and stall.
        step(1, 1, 1, mk(1, 32'h80, 5'd9, 4'h5, 5'b11111), BUB);
        // Invalid slot: enables and rd forced low, datapath as presented.
        step(0, 0, 0, mk(0, 32'h90, 5'd7, 4'h6, 5'b11111), LOAD);
        step(0, 0, 0, mk(1, 32'hA0, 5'd10, 4'h7, 5'b00011), LOAD);
        step(0, 0, 1, mk(1, 32'hA4, 5'd11, 4'h8, 5'b00100), BUB);
        step(0, 0, 1, mk(1, 32'hA4, 5'd11, 4'h8, 5'b00100), BUB);
        step(1, 0, 1, mk(1, 32'hA4, 5'd11, 4'h8, 5'b00100), BUB);
        step(0, 0, 0, mk(1, 32'hB0, 5'd12, 4'h9, 5'b01010), LOAD);
        step(0, 1, 0, mk(1, 32'hB4, 5'd13, 4'hA, 5'b10100), HOLD);
        step(1, 0, 0, mk(1, 32'hB8, 5'd14, 4'hB, 5'b00100), BUB);
        // Mid-stream async reset between edges.
        step(0, 0, 0, mk(1, 32'h100, 5'd3, 4'h2, 5'b00100), LOAD);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        cur = '0;
        ecnt = 32'd0;
        e.o = cur;
        e.cnt = ecnt;
        q.push_back(e);
        -> chk_ev;
        #1;
        step(0, 0, 0, mk(1, 32'h104, 5'd4, 4'h2, 5'b00100), LOAD);
        rst = 1'b0;
        step(0, 0, 0, mk(1, 32'h108, 5'd4, 4'hC, 5'b00100), LOAD);
`ifdef DE_STALL_CNT_EN
        @(negedge clk);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        ecnt = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(1, 32'h10C, 5'd4, 4'h1, 5'b00100), BUB);
`endif
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
